// File: rtl/i2s_mono_pcm16_if.sv
// Host/serial bundle for one mono I2S PCM16 unit.
// slave = the block's view, master = the driver's (host / link) view.
interface i2s_mono_pcm16_if;
  logic        enable;
  logic        sel_rx;
  logic        bclk;
  logic        lrclk;
  logic [4:0]  align;
  logic        rx;
  logic        tx;
  logic [15:0] rx_pcm;
  logic [15:0] tx_pcm;
  logic        full;
  logic        push;
  logic        pop;

  modport slave (
    input  enable, sel_rx, bclk, lrclk, align, rx, tx_pcm, push, pop,
    output tx, rx_pcm, full
  );

  modport master (
    output enable, sel_rx, bclk, lrclk, align, rx, tx_pcm, push, pop,
    input  tx, rx_pcm, full
  );
endinterface

// File: rtl/i2s_mono_pcm16.sv
// Mono I2S slave for 16-bit PCM, left slot only. bclk/lrclk/rx are sampled
// on clk as data; nothing here is clocked by them.
module i2s_mono_pcm16 #(
  parameter int W    = 16,
  parameter int SLOT = 32
) (
  input logic             clk,
  input logic             rstn,
  i2s_mono_pcm16_if.slave bus
);
  logic [1:0]   bclk_sy, lr_sy, rx_sy;
  logic         bclk_d, lr_d, push_q, pop_q, sel_q;
  logic         bclk_s, lr_s, rx_s;
  logic         bclk_rise, bclk_fall, lr_edge;
  logic [4:0]   p, p_next, a_eff;
  logic [5:0]   lo, hi;
  logic         pend, synced, synced_nx, restart, sel_chg, ack, left;
  logic         tx_act, tx_load, tx_bit, rx_act, rx_done, set_ev;
  logic [W-1:0] sh, tx_word, rx_word, rx_pcm_r;
  logic         tx_r, full_r;

  assign bclk_s = bclk_sy[1];
  assign lr_s   = lr_sy[1];
  assign rx_s   = rx_sy[1];

  assign bus.tx     = tx_r;
  assign bus.rx_pcm = rx_pcm_r;
  assign bus.full   = full_r;

  // Synchronizers, edge history and ack history keep running while disabled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bclk_sy <= '0;
      lr_sy   <= '0;
      rx_sy   <= '0;
      bclk_d  <= 1'b0;
      lr_d    <= 1'b0;
      push_q  <= 1'b0;
      pop_q   <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      bclk_sy <= {bclk_sy[0], bus.bclk};
      lr_sy   <= {lr_sy[0], bus.lrclk};
      rx_sy   <= {rx_sy[0], bus.rx};
      bclk_d  <= bclk_s;
      lr_d    <= lr_s;
      push_q  <= bus.push;
      pop_q   <= bus.pop;
      sel_q   <= bus.sel_rx;
    end
  end

  // Edge pulses, slot position and data-window decode.
  always_comb begin
    bclk_rise = bclk_s & ~bclk_d;
    bclk_fall = ~bclk_s & bclk_d;
    lr_edge   = lr_s ^ lr_d;
    left      = ~lr_s;
    a_eff     = (bus.align > 5'd16) ? 5'd16 : bus.align;
    lo        = {1'b0, a_eff};
    hi        = lo + 6'd15;
    sel_chg   = sel_q ^ bus.sel_rx;
    ack       = bus.sel_rx ? (bus.pop ^ pop_q) : (bus.push ^ push_q);
    // An lrclk edge seen between bclk falls is held in pend until the next fall.
    restart   = bclk_fall & (lr_edge | pend);
    p_next    = restart ? 5'd0 : ((p == 5'(SLOT - 1)) ? p : p + 5'd1);
    // synced gates all data activity so a slot entered part-way is dropped.
    synced_nx = ~sel_chg & (synced | restart);
    // Word load and first bit can share a fall when align is 0.
    tx_word   = (p_next == 5'd0) ? bus.tx_pcm : sh;
    tx_act    = bus.enable & ~bus.sel_rx & ~sel_chg & bclk_fall & synced_nx & left;
    tx_load   = tx_act & (p_next == 5'd0);
    tx_bit    = tx_act & ({1'b0, p_next} >= lo) & ({1'b0, p_next} <= hi);
    rx_word   = {sh[W-2:0], rx_s};
    rx_act    = bus.enable & bus.sel_rx & ~sel_chg & bclk_rise & synced & left &
                ({1'b0, p} >= lo) & ({1'b0, p} <= hi);
    rx_done   = rx_act & ({1'b0, p} == hi);
    set_ev    = tx_load | rx_done;
  end

  // Slot tracking, serial shift path and the full flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p      <= '0;
      pend   <= 1'b0;
      synced <= 1'b0;
      sh     <= '0;
      tx_r   <= 1'b0;
      full_r <= 1'b0;
    end else if (!bus.enable) begin
      p      <= '0;
      pend   <= 1'b0;
      synced <= 1'b0;
      sh     <= '0;
      tx_r   <= 1'b0;
      full_r <= 1'b0;
    end else begin
      pend   <= bclk_fall ? 1'b0 : (pend | lr_edge);
      synced <= synced_nx;
      if (bclk_fall) p <= p_next;
      if (sel_chg) begin
        sh   <= '0;
        tx_r <= 1'b0;
      end else if (bus.sel_rx) begin
        tx_r <= 1'b0;
        if (rx_act) sh <= rx_word;
      end else if (bclk_fall) begin
        if (tx_bit) begin
          tx_r <= tx_word[W-1];
          sh   <= {tx_word[W-2:0], 1'b0};
        end else begin
          tx_r <= 1'b0;
          if (tx_act) sh <= tx_word;
        end
      end
      // A new sample event beats a same-cycle acknowledge.
      if (set_ev)   full_r <= 1'b1;
      else if (ack) full_r <= 1'b0;
    end
  end

  // Received word register; holds through disable, overwritten on overrun.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        rx_pcm_r <= '0;
    else if (rx_done) rx_pcm_r <= rx_word;
  end
endmodule

// File: tb/tb_i2s_mono_pcm16.sv
// Loopback bench: unit A transmits, unit B receives; words expected at B are
// queued when A's sample is presented and checked when B raises full.
module tb_i2s_mono_pcm16;
  logic clk, rstn;
  logic bclk, lrclk, junk, ack_a;
  int   ph, pos;
  int   total, bad;
  int   a_cnt, b_cnt, a_wait, b_wait;
  logic a_prev, b_prev;
  logic [15:0] q[$];
  logic [17:0] wave;
  logic        acc;

  i2s_mono_pcm16_if ia ();
  i2s_mono_pcm16_if ib ();

  assign ia.bclk  = bclk;
  assign ib.bclk  = bclk;
  assign ia.lrclk = lrclk;
  assign ib.lrclk = lrclk;
  assign ia.rx    = 1'b0;
  assign ib.rx    = ia.tx | (junk & lrclk);

  i2s_mono_pcm16 u_a (.clk(clk), .rstn(rstn), .bus(ia.slave));
  i2s_mono_pcm16 u_b (.clk(clk), .rstn(rstn), .bus(ib.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // bclk = clk/8, 32 bclk per half-frame, lrclk changes on bclk fall
  initial begin
    bclk = 1'b0; lrclk = 1'b1; ph = 0; pos = 0;
    forever begin
      @(negedge clk);
      ph++;
      if (ph == 4) begin
        ph = 0;
        bclk = ~bclk;
        if (!bclk) begin
          pos++;
          if (pos == 32) begin
            pos = 0;
            lrclk = ~lrclk;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // host side: score B words, acknowledge both units, check flags clear
  initial begin
    logic [15:0] e;
    ia.push = 1'b0; ib.pop = 1'b0;
    a_prev = 1'b0; b_prev = 1'b0;
    a_cnt = 0; b_cnt = 0; a_wait = 0; b_wait = 0;
    forever begin
      @(negedge clk);
      if (b_wait == 1) chk("pop_clear", 32'(ib.full), 32'd0);
      if (b_wait != 0) b_wait--;
      if (a_wait == 1) chk("push_clear", 32'(ia.full), 32'd0);
      if (a_wait != 0) a_wait--;
      if (ib.full && !b_prev) begin
        b_cnt++;
        chk("sb_nonempty", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("rx_pcm", 32'(ib.rx_pcm), 32'(e));
        end
        ib.pop = ~ib.pop;
        b_wait = 2;
      end
      if (ia.full && !a_prev) begin
        a_cnt++;
        if (ack_a) begin
          ia.push = ~ia.push;
          a_wait = 2;
        end
      end
      a_prev = ia.full;
      b_prev = ib.full;
    end
  end

  task automatic wait_lr_rise();
    @(posedge lrclk);
    repeat (4) @(negedge clk);
  endtask

  // present a new sample during the right slot; B should see it next left slot
  task automatic send(input logic [15:0] v, input logic [4:0] al);
    wait_lr_rise();
    ia.align  = al;
    ib.align  = al;
    ia.tx_pcm = v;
    q.push_back(v);
  endtask

  // A's tx at left-slot positions 0..17, bit k = position k
  task automatic capture(output logic [17:0] v);
    v = '0;
    @(negedge lrclk);
    for (int k = 0; k < 18; k++) begin
      repeat (5) @(negedge clk);
      v[k] = ia.tx;
      repeat (3) @(negedge clk);
    end
  endtask

  initial begin
    total = 0; bad = 0; junk = 1'b0; ack_a = 1'b1;
    rstn = 1'b0;
    ia.enable = 1'b0; ia.sel_rx = 1'b0; ia.align = 5'd1; ia.tx_pcm = 16'hFFFF;
    ib.enable = 1'b0; ib.sel_rx = 1'b1; ib.align = 5'd1; ib.tx_pcm = 16'h0000;

    repeat (3) @(negedge clk);
    chk("rst_a_tx",   32'(ia.tx),     32'd0);
    chk("rst_a_full", 32'(ia.full),   32'd0);
    chk("rst_a_pcm",  32'(ia.rx_pcm), 32'd0);
    chk("rst_b_tx",   32'(ib.tx),     32'd0);
    chk("rst_b_full", 32'(ib.full),   32'd0);
    chk("rst_b_pcm",  32'(ib.rx_pcm), 32'd0);

    rstn = 1'b1;
    for (int i = 0; i < 16; i++) begin
      repeat (64) @(negedge clk);
      chk("idle_tx",   32'(ia.tx | ib.tx),     32'd0);
      chk("idle_full", 32'(ia.full | ib.full), 32'd0);
      chk("idle_pcm",  32'(ib.rx_pcm),         32'd0);
    end

    // loopback, standard I2S
    wait_lr_rise();
    ia.tx_pcm = 16'h1234;
    q.push_back(16'h1234);
    ia.enable = 1'b1; ib.enable = 1'b1;
    repeat (3) send(16'h1234, 5'd1);
    send(16'h8001, 5'd0);
    chk("frames_b", 32'(b_cnt), 32'd4);
    chk("frames_a", 32'(a_cnt), 32'd4);
    chk("sb_level", 32'(q.size()), 32'd1);

    // sign and alignment
    capture(wave);
    chk("wave_align0", 32'(wave), 32'h08001);
    send(16'h8001, 5'd1);
    capture(wave);
    chk("wave_align1", 32'(wave), 32'h10002);

    // right slot: new sample and junk on B's rx must not appear
    send(16'hFFFF, 5'd1);
    junk = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 27; k++) begin
      repeat (8) @(negedge clk);
      acc = acc | ia.tx;
    end
    chk("right_tx", 32'(acc), 32'd0);
    chk("right_pcm", 32'(ib.rx_pcm), 32'h8001);
    send(16'h0F0F, 5'd1);

    // mid-frame disable at bit position 8
    ack_a = 1'b0;
    send(16'hFFFF, 5'd1);
    @(negedge lrclk);
    repeat (69) @(negedge clk);
    chk("mid_tx", 32'(ia.tx), 32'd1);
    chk("mid_full", 32'(ia.full), 32'd1);
    ia.enable = 1'b0; ib.enable = 1'b0;
    @(negedge clk);
    chk("dis_tx", 32'(ia.tx), 32'd0);
    chk("dis_full_a", 32'(ia.full), 32'd0);
    chk("dis_full_b", 32'(ib.full), 32'd0);
    chk("dis_pcm", 32'(ib.rx_pcm), 32'h0F0F);
    if (q.size() > 0) void'(q.pop_front());
    repeat (32) @(negedge clk);
    ack_a = 1'b1;
    ia.enable = 1'b1; ib.enable = 1'b1;
    send(16'h5A5A, 5'd1);
    wait_lr_rise();
    chk("reen_sb", 32'(q.size()), 32'd0);
    chk("reen_pcm", 32'(ib.rx_pcm), 32'h5A5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
